// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO block: register offsets, pin-count limit,
// and the byte-enable expansion helper used by the register file.
package gpio_pkg;

  localparam int MAX_NGPIO = 32;

  localparam logic [7:0] ADDR_MODE     = 8'h00;
  localparam logic [7:0] ADDR_OUT      = 8'h04;
  localparam logic [7:0] ADDR_IN       = 8'h08;
  localparam logic [7:0] ADDR_OUT_SET  = 8'h0C;
  localparam logic [7:0] ADDR_OUT_CLR  = 8'h10;
  localparam logic [7:0] ADDR_OUT_TGL  = 8'h14;
  localparam logic [7:0] ADDR_RISE_EN  = 8'h18;
  localparam logic [7:0] ADDR_FALL_EN  = 8'h1C;
  localparam logic [7:0] ADDR_PEND     = 8'h20;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h24;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pad synchronizer plus one extra registered copy for edge detection.
// Edges are suppressed until the chain has refilled after reset release.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int NGPIO       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [NGPIO-1:0] i_pin,
  output logic [NGPIO-1:0] o_sync,
  output logic [NGPIO-1:0] o_rise,
  output logic [NGPIO-1:0] o_fall
);

  localparam logic [2:0] INHIBIT = 3'(SYNC_STAGES + 1);

  logic [NGPIO-1:0] sync_p [SYNC_STAGES];
  logic [NGPIO-1:0] prev_p;
  logic [2:0]       inh_cnt;
  logic             edge_en;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= i_pin;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  // A pin already high at release would look like a rising edge while the
  // chain fills, so detection waits until every stage holds real samples.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      inh_cnt <= '0;
    else if (inh_cnt != INHIBIT)
      inh_cnt <= inh_cnt + 3'd1;
  end

  assign edge_en = (inh_cnt == INHIBIT);
  assign o_sync  = sync_p[SYNC_STAGES-1];
  assign o_rise  = o_sync & ~prev_p & {NGPIO{edge_en}};
  assign o_fall  = ~o_sync & prev_p & {NGPIO{edge_en}};

endmodule

// File: rtl/gpio_irq2rib.sv
// GPIO block on a RIB slave port: direction/output registers, synchronized
// input readback, per-pin edge interrupts with W1C pending and a level irq.
module gpio_irq2rib
  import gpio_pkg::*;
#(
  parameter int NGPIO       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [31:0]      i_ribs_addr,
  input  logic             i_ribs_wrcs,
  input  logic [3:0]       i_ribs_mask,
  input  logic [31:0]      i_ribs_wdata,
  output logic [31:0]      o_ribs_rdata,
  input  logic             i_ribs_req,
  output logic             o_ribs_gnt,
  output logic             o_ribs_rsp,
  input  logic             i_ribs_rdy,
  output logic [NGPIO-1:0] o_gpio_mode,
  input  logic [NGPIO-1:0] i_gpio_in,
  output logic [NGPIO-1:0] o_gpio_out,
  output logic             o_irq
);

  logic             rsp_q;
  logic             acc, wr_acc, rd_acc;
  logic [7:0]       reg_addr;
  logic [31:0]      bm, wd_m;
  logic [NGPIO-1:0] bm_n, wbits, w1c;
  logic [NGPIO-1:0] mode_q, out_q, rise_en_q, fall_en_q, pend_q, irq_mask_q;
  logic [NGPIO-1:0] in_sync, rise, fall, edge_hit;
  logic [31:0]      rd_val;
  logic             unused_bits;

  assign o_ribs_gnt = i_ribs_req & (~rsp_q | i_ribs_rdy);
  assign o_ribs_rsp = rsp_q;
  assign acc        = i_ribs_req & o_ribs_gnt;
  assign wr_acc     = acc & i_ribs_wrcs;
  assign rd_acc     = acc & ~i_ribs_wrcs;
  assign reg_addr   = {i_ribs_addr[7:2], 2'b00};

  assign bm    = byte_mask(i_ribs_mask);
  assign wd_m  = i_ribs_wdata & bm;
  assign bm_n  = bm[NGPIO-1:0];
  assign wbits = wd_m[NGPIO-1:0];
  assign unused_bits = ^{i_ribs_addr[31:8], i_ribs_addr[1:0], bm, wd_m};

  gpio_sync #(
    .NGPIO       (NGPIO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_pin  (i_gpio_in),
    .o_sync (in_sync),
    .o_rise (rise),
    .o_fall (fall)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mode_q     <= '0;
      out_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
    end else if (wr_acc) begin
      case (reg_addr)
        ADDR_MODE:     mode_q     <= (mode_q & ~bm_n) | wbits;
        ADDR_OUT:      out_q      <= (out_q & ~bm_n) | wbits;
        ADDR_OUT_SET:  out_q      <= out_q | wbits;
        ADDR_OUT_CLR:  out_q      <= out_q & ~wbits;
        ADDR_OUT_TGL:  out_q      <= out_q ^ wbits;
        ADDR_RISE_EN:  rise_en_q  <= (rise_en_q & ~bm_n) | wbits;
        ADDR_FALL_EN:  fall_en_q  <= (fall_en_q & ~bm_n) | wbits;
        ADDR_IRQ_MASK: irq_mask_q <= (irq_mask_q & ~bm_n) | wbits;
        default: ;
      endcase
    end
  end

  // Clear is applied before set so an edge arriving with the W1C survives.
  assign w1c      = (wr_acc && reg_addr == ADDR_PEND) ? wbits : '0;
  assign edge_hit = (rise & rise_en_q) | (fall & fall_en_q);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q <= '0;
      o_irq  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~w1c) | edge_hit;
      o_irq  <= |(pend_q & irq_mask_q);
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      ADDR_MODE:     rd_val[NGPIO-1:0] = mode_q;
      ADDR_OUT:      rd_val[NGPIO-1:0] = out_q;
      ADDR_IN:       rd_val[NGPIO-1:0] = in_sync;
      ADDR_RISE_EN:  rd_val[NGPIO-1:0] = rise_en_q;
      ADDR_FALL_EN:  rd_val[NGPIO-1:0] = fall_en_q;
      ADDR_PEND:     rd_val[NGPIO-1:0] = pend_q;
      ADDR_IRQ_MASK: rd_val[NGPIO-1:0] = irq_mask_q;
      default: ;
    endcase
  end

  // Response stays up until the master takes it; a fresh grant re-arms it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rsp_q        <= 1'b0;
      o_ribs_rdata <= '0;
    end else begin
      if (acc)
        rsp_q <= 1'b1;
      else if (i_ribs_rdy)
        rsp_q <= 1'b0;
      if (rd_acc)
        o_ribs_rdata <= rd_val;
    end
  end

  assign o_gpio_mode = mode_q;
  assign o_gpio_out  = out_q;

endmodule

// File: tb/tb_gpio_irq2rib.sv
// Directed bench for gpio_irq2rib: bus protocol, register map, edge irq
// path, W1C/edge collision and reset behaviour.
module tb_gpio_irq2rib;
  localparam int NGPIO = 24;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [31:0]      addr = '0;
  logic             wrcs = 1'b0;
  logic [3:0]       mask = '0;
  logic [31:0]      wdata = '0;
  logic [31:0]      rdata;
  logic             req = 1'b0;
  logic             gnt;
  logic             rsp;
  logic             rdy = 1'b1;
  logic [NGPIO-1:0] mode;
  logic [NGPIO-1:0] gin = '0;
  logic [NGPIO-1:0] gout;
  logic             irq;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] rv;
  logic        rs;

  always #5 clk = ~clk;

  gpio_irq2rib #(.NGPIO(NGPIO), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_ribs_addr  (addr),
    .i_ribs_wrcs  (wrcs),
    .i_ribs_mask  (mask),
    .i_ribs_wdata (wdata),
    .o_ribs_rdata (rdata),
    .i_ribs_req   (req),
    .o_ribs_gnt   (gnt),
    .o_ribs_rsp   (rsp),
    .i_ribs_rdy   (rdy),
    .o_gpio_mode  (mode),
    .i_gpio_in    (gin),
    .o_gpio_out   (gout),
    .o_irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Called just after a rising edge; returns just after the edge that
  // follows the response cycle. rs/rd are sampled one cycle after grant.
  task automatic bus_acc(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] m, output logic [31:0] rd, output logic rs_o);
    int n;
    addr = {24'h0, a}; wrcs = wr; wdata = wd; mask = m; req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!gnt && n < 20) begin n++; @(negedge clk); end
    if (!gnt) check("gnt_timeout", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; wrcs = 1'b0;
    rd = rdata; rs_o = rsp;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] dummy; logic r;
    bus_acc(1'b1, a, d, m, dummy, r);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    logic r;
    bus_acc(1'b0, a, 32'h0, 4'hF, d, r);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_rsp", 32'(rsp), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk); rstn = 1'b1;
    cycles(6);

    // MODE with partial byte mask, then read latency
    wr(8'h00, 32'h00ABFF00, 4'b0011);
    bus_acc(1'b0, 8'h00, 32'h0, 4'hF, rv, rs);
    check("mode_rsp_lat", 32'(rs), 32'h1);
    check("mode_rd", rv, 32'h0000FF00);
    check("mode_pin", 32'(mode), 32'h00FF00);

    // OUT set/clr/toggle: 0F0F |F0 -> 0FFF &~0F -> 0FF0 ^1001 -> 1FF1
    wr(8'h04, 32'h00000F0F, 4'hF);
    wr(8'h0C, 32'h000000F0, 4'hF);
    wr(8'h10, 32'h0000000F, 4'hF);
    wr(8'h14, 32'h00001001, 4'hF);
    rd(8'h04, rv);
    check("out_rd", rv, 32'h00001FF1);
    check("out_pin", 32'(gout), 32'h001FF1);
    rd(8'h0C, rv);
    check("outset_rd0", rv, 32'h0);
    wr(8'h04, 32'hFFFFFFFF, 4'hF);
    rd(8'h04, rv);
    check("out_width", rv, 32'h00FFFFFF);

    // IN readback, read-only IN, unmapped address
    gin = 24'hA50000;
    cycles(4);
    wr(8'h08, 32'h00000000, 4'hF);
    rd(8'h08, rv);
    check("in_rd", rv, 32'h00A50000);
    rd(8'h3C, rv);
    check("unmapped_rd", rv, 32'h0);
    gin = '0;
    cycles(4);

    // Rising edge on pin0 -> PEND after 3 edges, irq one later, W1C clears
    wr(8'h18, 32'h1, 4'hF);
    wr(8'h24, 32'h1, 4'hF);
    gin[0] = 1'b1;
    cycles(3);
    check("irq_pre", 32'(irq), 32'h0);
    cycles(1);
    check("irq_set", 32'(irq), 32'h1);
    rd(8'h20, rv);
    check("pend_set", rv, 32'h1);
    wr(8'h20, 32'h1, 4'hF);
    check("irq_clr", 32'(irq), 32'h0);
    rd(8'h20, rv);
    check("pend_clr", rv, 32'h0);

    // Falling edge on pin3 colliding with its W1C
    gin[3] = 1'b1;
    wr(8'h1C, 32'h8, 4'hF);
    cycles(4);
    gin[3] = 1'b0;
    cycles(5);
    rd(8'h20, rv);
    check("pend3_fall", rv, 32'h8);
    gin[3] = 1'b1;
    cycles(5);
    gin[3] = 1'b0;
    cycles(2);
    wr(8'h20, 32'h8, 4'hF);
    rd(8'h20, rv);
    check("pend3_collide", rv, 32'h8);
    wr(8'h20, 32'h8, 4'hF);
    rd(8'h20, rv);
    check("pend3_w1c", rv, 32'h0);

    // Backpressure: response held while rdy low, second request stalled
    rdy = 1'b0;
    addr = 32'h0; wrcs = 1'b0; mask = 4'hF; req = 1'b1;
    @(negedge clk);
    check("bp_gnt1", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_gnt0", 32'(gnt), 32'h0);
      check("bp_rsp", 32'(rsp), 32'h1);
      check("bp_rdata", rdata, 32'h0000FF00);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    #1;
    check("bp_gnt_rdy", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = 1'b0;
    check("b2b_rsp", 32'(rsp), 32'h1);
    check("b2b_rdata", rdata, 32'h00FFFFFF);
    @(posedge clk); #1;
    check("b2b_rsp_drop", 32'(rsp), 32'h0);

    // Reset with a response pending and irq high
    gin[0] = 1'b0;
    cycles(5);
    gin[0] = 1'b1;
    cycles(5);
    check("irq_before_rst", 32'(irq), 32'h1);
    rdy = 1'b0;
    addr = 32'h0; wrcs = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    gin[1] = 1'b1;
    rstn = 1'b0;
    #1;
    check("rst_rsp_drop", 32'(rsp), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_out", 32'(gout), 32'h0);
    check("rst_mode2", 32'(mode), 32'h0);
    check("rst_irq2", 32'(irq), 32'h0);
    rdy = 1'b1;
    gin[1] = 1'b0;
    cycles(2);
    @(negedge clk);
    rstn = 1'b1;
    addr = 32'h18; wrcs = 1'b1; wdata = 32'h1; mask = 4'hF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; wrcs = 1'b0;
    check("post_rst_rsp", 32'(rsp), 32'h1);
    cycles(4);
    rd(8'h20, rv);
    check("no_spurious_pend", rv, 32'h0);
    gin[0] = 1'b0;
    cycles(5);
    gin[0] = 1'b1;
    cycles(5);
    rd(8'h20, rv);
    check("post_rst_edge", rv, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
